// File: rtl/sdf_pkg.sv
// Shared definitions for the SDF FFT stage controllers: state encoding and
// small constant helpers used to size and address each stage.
package sdf_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } sdf_state_e;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Twiddle exponent for sample k of a stage: k * 2^(STAGE_NO-1)
  function automatic int unsigned tw_exp(input int unsigned k, input int stage_no);
    return k << (stage_no - 1);
  endfunction

endpackage

// File: rtl/sdf_stage_ctrl.sv
// Per-stage SDF FFT/IFFT controller: butterfly mux select, twiddle address and
// conjugate flag, output framing, stall handling and delay-line drain.
module sdf_stage_ctrl
  import sdf_pkg::*;
#(
  parameter  int NFFT     = 128,
  parameter  int STAGE_NO = 1,
  localparam int LOG2N    = clog2_f(NFFT),
  localparam int LOG2D    = LOG2N - STAGE_NO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             sel,
  output logic [LOG2N-2:0] tw_addr,
  output logic             tw_en,
  output logic             tw_conj,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int D = NFFT >> STAGE_NO;
  localparam logic [LOG2N-1:0] CNT_FILL_END = LOG2N'(D - 1);
  localparam logic [LOG2N-1:0] CNT_MAX      = LOG2N'(NFFT - 1);

  sdf_state_e       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             adv;

  always_comb begin
    adv = 1'b0;
    case (state_q)
      S_FILL, S_RUN: adv = in_valid;
      S_DRAIN:       adv = 1'b1;
      default:       adv = 1'b0;
    endcase

    state_d = state_q;
    cnt_d   = adv ? cnt_q + LOG2N'(1) : cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          cnt_d   = '0;
          err_d   = 1'b0;
          mode_d  = mode;
        end
      end
      S_FILL: begin
        if (adv) begin
          if (in_last) err_d = 1'b1;
          if (cnt_q == CNT_FILL_END) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A misplaced in_last is flagged but the run carries on.
        if (adv && in_last) begin
          if (cnt_q == CNT_MAX) state_d = S_DRAIN;
          else                  err_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_FILL_END) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign sel       = busy & cnt_q[LOG2D];
  assign out_valid = adv & ((state_q == S_RUN) | (state_q == S_DRAIN));
  assign tw_en     = out_valid & ~sel;
  assign out_last  = (state_q == S_DRAIN) & (cnt_q == CNT_FILL_END);
  assign tw_conj   = busy & mode_q;
  assign done      = done_q;
  assign err       = err_q;

  generate
    if (LOG2D == 0) begin : g_tw_last
      assign tw_addr = '0;
    end else begin : g_tw
      logic [LOG2D-1:0] k;
      assign k       = cnt_q[LOG2D-1:0];
      assign tw_addr = tw_en ? (LOG2N-1)'(tw_exp(32'(k), STAGE_NO)) : '0;
    end
  endgenerate

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: three NFFT=8 stages share one stimulus stream and
// are compared each cycle against a sample-index based reference model.
module tb_sdf_stage_ctrl;
  localparam int N = 8;

  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, mode = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic sel_o[3], twen_o[3], conj_o[3], ov_o[3], last_o[3], busy_o[3], done_o[3], err_o[3];
  logic [1:0] twa_o[3];

  always #5 clk = ~clk;

  sdf_stage_ctrl #(.NFFT(N), .STAGE_NO(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid), .in_last(in_last),
    .sel(sel_o[0]), .tw_addr(twa_o[0]), .tw_en(twen_o[0]), .tw_conj(conj_o[0]),
    .out_valid(ov_o[0]), .out_last(last_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]));
  sdf_stage_ctrl #(.NFFT(N), .STAGE_NO(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid), .in_last(in_last),
    .sel(sel_o[1]), .tw_addr(twa_o[1]), .tw_en(twen_o[1]), .tw_conj(conj_o[1]),
    .out_valid(ov_o[1]), .out_last(last_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]));
  sdf_stage_ctrl #(.NFFT(N), .STAGE_NO(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid), .in_last(in_last),
    .sel(sel_o[2]), .tw_addr(twa_o[2]), .tw_en(twen_o[2]), .tw_conj(conj_o[2]),
    .out_valid(ov_o[2]), .out_last(last_o[2]), .busy(busy_o[2]), .done(done_o[2]), .err(err_o[2]));

  // Reference model: m_n counts accepted inputs of the run, m_j counts drain cycles.
  int m_n[3], m_j[3];
  bit m_busy[3], m_drain[3], m_err[3], m_done[3];
  bit m_mode;
  int n_chk = 0, n_fail = 0;
  int oc[3];

  function automatic logic [9:0] mexp(int s, logic v);
    int d, p;
    logic sl, ov, te, lst;
    logic [1:0] ta;
    d = N >> (s + 1);
    sl = 0; ov = 0; te = 0; lst = 0; ta = 0;
    if (m_busy[s]) begin
      p   = m_drain[s] ? m_n[s] + m_j[s] : m_n[s];
      sl  = ((p / d) % 2) == 1;
      ov  = m_drain[s] ? 1'b1 : (v && m_n[s] >= d);
      te  = ov && !sl;
      ta  = te ? 2'((p % d) << s) : 2'd0;
      lst = m_drain[s] && (m_j[s] == d - 1);
    end
    return {sl, ta, te, m_busy[s] & m_mode, ov, lst, m_busy[s], m_done[s], m_err[s]};
  endfunction

  task automatic model_step(input logic st, input logic md, input logic v, input logic l);
    for (int s = 0; s < 3; s++) begin
      int d;
      bit dn;
      d = N >> (s + 1);
      dn = 0;
      if (!m_busy[s]) begin
        if (st) begin
          m_busy[s] = 1; m_n[s] = 0; m_drain[s] = 0; m_err[s] = 0; m_mode = md;
        end
      end else if (m_drain[s]) begin
        if (m_j[s] == d - 1) begin m_busy[s] = 0; dn = 1; end
        else m_j[s]++;
      end else if (v) begin
        if (l) begin
          if (m_n[s] < d || (m_n[s] % N) != N - 1) m_err[s] = 1;
          else begin m_drain[s] = 1; m_j[s] = 0; end
        end
        m_n[s]++;
      end
      m_done[s] = dn;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_n[s] = 0; m_j[s] = 0; m_busy[s] = 0; m_drain[s] = 0; m_err[s] = 0; m_done[s] = 0;
    end
    m_mode = 0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int s = 0; s < 3; s++) begin
      logic [9:0] act, exp;
      exp = mexp(s, in_valid);
      act = {sel_o[s], twa_o[s], twen_o[s], conj_o[s], ov_o[s], last_o[s], busy_o[s], done_o[s], err_o[s]};
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL stage%0d outputs sel/twa/twen/conj/ov/last/busy/done/err: got %b want %b at %0t",
                 s + 1, act, exp, $time);
      end
      if (ov_o[s]) oc[s]++;
    end
  endtask

  task automatic drive(input logic st, input logic md, input logic v, input logic l);
    start = st; mode = md; in_valid = v; in_last = l;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(start, mode, in_valid, in_last);
    #1;
  endtask

  task automatic cycle(input logic st, input logic md, input logic v, input logic l);
    drive(st, md, v, l);
    @(negedge clk);
    check_model();
    tick();
  endtask

  task automatic clr_oc();
    for (int s = 0; s < 3; s++) oc[s] = 0;
  endtask

  task automatic chk_oc(input string nm, input int exp);
    for (int s = 0; s < 3; s++) chk($sformatf("%s_count_stage%0d", nm, s + 1), oc[s], exp);
  endtask

  // {sel, out_valid, tw_en, tw_addr[1:0], out_last, done, busy} for stage 1
  typedef struct {
    logic st, v, l;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'b0000_0000};
    for (int i = 1; i <= 4; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 8'b0000_0001};
    for (int i = 5; i <= 7; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 8'b1100_0001};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'b1100_0001};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'b0110_0001};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'b0110_1001};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'b0111_0001};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'b0111_1101};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'b0000_0010};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'b0000_0000};

    model_reset();
    clr_oc();
    @(negedge clk);
    check_model();
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 1);

    // Single frame, table driven for stage 1, model checked for all stages
    clr_oc();
    for (int i = 0; i < 15; i++) begin
      logic [7:0] a;
      drive(tbl[i].st, 1'b0, tbl[i].v, tbl[i].l);
      @(negedge clk);
      a = {sel_o[0], ov_o[0], twen_o[0], twa_o[0], last_o[0], done_o[0], busy_o[0]};
      chk($sformatf("table_row%0d", i), int'(a), int'(tbl[i].exp));
      check_model();
      tick();
    end
    chk_oc("single", 8);

    // Three back-to-back IFFT frames, stall, misplaced in_last, start while busy
    clr_oc();
    cycle(1, 1, 0, 0);
    for (int k = 0; k < 24; k++) begin
      if (k == 12) begin
        logic sel_hold;
        sel_hold = 1'b0;
        for (int g = 0; g < 3; g++) begin
          drive(0, 1, 0, 0);
          @(negedge clk);
          if (g == 0) sel_hold = sel_o[1];
          chk("stall_out_valid", int'(ov_o[1]), 0);
          chk("stall_sel_hold", int'(sel_o[1]), int'(sel_hold));
          check_model();
          tick();
        end
      end
      drive(k == 10, 1, 1, (k == 5) || (k == 23));
      @(negedge clk);
      if (ov_o[1]) chk("ifft_conj", int'(conj_o[1]), 1);
      check_model();
      tick();
    end
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);
    chk_oc("b2b", 24);
    chk("err_sticky", int'(err_o[0]), 1);
    cycle(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("err_cleared", int'(err_o[0]), 0);
    check_model();
    tick();
    for (int k = 0; k < 8; k++) cycle(0, 0, 1, k == 7);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);

    // Asynchronous reset in the middle of stage 1 drain
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) cycle(0, 0, 1, k == 7);
    cycle(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    check_model();
    #1 rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      logic [9:0] act;
      act = {sel_o[s], twa_o[s], twen_o[s], conj_o[s], ov_o[s], last_o[s], busy_o[s], done_o[s], err_o[s]};
      chk($sformatf("async_reset_stage%0d", s + 1), int'(act), 0);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    clr_oc();
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) cycle(0, 0, 1, k == 7);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    chk_oc("post_reset", 8);

    // Randomised runs
    for (int r = 0; r < 12; r++) begin
      int f, k, gap;
      logic md, v, l, st;
      f   = $urandom_range(1, 3);
      md  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cycle(0, md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      clr_oc();
      cycle(1, md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      k = 0;
      for (int c = 0; c < 400 && k < f * N; c++) begin
        v = ($urandom_range(0, 3) != 0);
        l = 1'b0;
        if (v) begin
          if (k == f * N - 1) l = 1'b1;
          else if ((k % N) != N - 1 && $urandom_range(0, 15) == 0) l = 1'b1;
        end else begin
          l = 1'($urandom_range(0, 1));
        end
        st = ($urandom_range(0, 9) == 0);
        cycle(st, md, v, l);
        if (v) k++;
      end
      for (int i = 0; i < 6; i++) cycle(0, md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk_oc($sformatf("rand%0d", r), f * N);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdf_stage_ctrl.md
# sdf_stage_ctrl

Parametrised per-stage controller for the single-delay-feedback (SDF) FFT/IFFT pipeline. It replaces fixed-size, IFFT-only mux controllers with one block for any power-of-two NFFT and any stage. It drives the stage butterfly/feedback mux select, twiddle ROM address and conjugate flag, and output-valid/last framing. It also supports stalled input, back-to-back frames and an automatic drain of the delay line after the final frame. One instance sits beside each stage's butterfly and delay line.

## Interface
- NFFT, 128, transform size; power of two, at least 4
- STAGE_NO, 1, stage index from 1 to log2(NFFT); delay-line depth D = NFFT >> STAGE_NO
- Derived constants: LOG2N = log2(NFFT), LOG2D = LOG2N − STAGE_NO
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle arm request; honoured only in IDLE
- mode  in  1  0 = FFT, 1 = IFFT; latched on an accepted start
- in_valid  in  1  input sample present this cycle
- in_last  in  1  qualifies in_valid; marks the final sample of the final frame
- sel  out  1  butterfly mux select; 0 = fill/feedback, 1 = butterfly
- tw_addr  out  LOG2N−1  twiddle ROM address, exponent k·2^(STAGE_NO−1)
- tw_en  out  1  twiddle multiply enable for the current output sample
- tw_conj  out  1  conjugate twiddle (IFFT)
- out_valid  out  1  stage output sample valid
- out_last  out  1  final output sample of the run
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on return to IDLE after drain
- err  out  1  sticky protocol error; cleared by an accepted start

## Operation
- The FSM has four states: IDLE, FILL, RUN and DRAIN.
- cnt is a LOG2N-bit sample counter, wrapping modulo NFFT.
- adv = in_valid in FILL or RUN; adv = 1 in DRAIN; adv = 0 in IDLE. cnt increments only on adv.
- sel = cnt[LOG2D] in every non-IDLE state; sel = 0 in IDLE. The pattern per frame is D samples with sel = 0, then D with sel = 1, repeating.
- out_valid = adv in RUN or DRAIN.
- tw_en = out_valid & ~sel.
- tw_addr = cnt[LOG2D−1:0] << (STAGE_NO−1) when tw_en is 1, else 0. For the last stage (D = 1), tw_addr is always 0.
- tw_conj = latched mode while busy, else 0.
- State transitions:
  - IDLE → FILL on start. Clears cnt and err, latches mode. in_valid and in_last are ignored in IDLE, including in the start cycle.
  - FILL → RUN on adv with cnt = D−1. No output is produced in FILL.
  - RUN → DRAIN on adv with in_last and cnt = NFFT−1; cnt wraps to 0. Frames otherwise continue back-to-back with no gap.
  - DRAIN → IDLE on the cycle with cnt = D−1. That cycle asserts out_last; done pulses the following cycle. in_valid is ignored in DRAIN.
- in_last with cnt ≠ NFFT−1 sets err and is otherwise ignored; the run continues. in_last during FILL also sets err.
- start while busy is ignored and does not set err.
- The total number of outputs equals the number of inputs; output lags input by D advances.

## Timing
- Reset values: state IDLE, cnt 0, and every output 0 (sel, tw_addr, tw_en, tw_conj, out_valid, out_last, busy, done, err).
- Registered state: cnt, state, mode latch, err, done.
- sel, tw_*, out_valid and out_last are combinational from registered state and in_valid. There is no extra pipeline stage; they align with the sample presented in the same cycle.
- A sample can be accepted from the cycle after start.
- Drain length is exactly D cycles, independent of in_valid.
- Stall: with in_valid = 0 in FILL or RUN, cnt holds, out_valid = 0, and sel holds its value.
- Reset asserted mid-run returns the block to IDLE immediately (asynchronously) with no done pulse.

## Structure
- Shared package sdf_pkg holds:
  - the state encoding (2-bit enumeration: IDLE, FILL, RUN, DRAIN);
  - a log2 helper function;
  - a twiddle-exponent helper, k << (STAGE_NO−1).
- No sub-module is needed. The twiddle ROM is external, shared by the stage datapath, and addressed by tw_addr.

## Test plan
- **Single frame, stage 1** (NFFT = 8, STAGE_NO = 1, D = 4): start, then 8 contiguous valid inputs with in_last on the 8th.
  - sel pattern over inputs: 0,0,0,0,1,1,1,1.
  - out_valid is first high on input 5, then stays high for 4 drain cycles (8 outputs total).
  - tw_addr over tw_en outputs: 0,1,2,3. out_last on the 8th output, done on the next cycle.
- **Last stage** (NFFT = 8, STAGE_NO = 3, D = 1): sel toggles 0,1,0,1,…; tw_addr stays 0; drain is 1 cycle.
- **Back-to-back frames and mode** (NFFT = 8, STAGE_NO = 2): 3 frames with mode = 1, in_last only on sample 24.
  - Exactly 24 outputs; tw_conj = 1 throughout.
  - tw_addr sequence on tw_en outputs repeats 0,2.
- **Stall**: in_valid deasserted for 3 cycles mid-RUN. cnt and sel hold, out_valid = 0 during the gap, and the output count is unchanged.
- **Protocol errors**:
  - in_last at cnt = 5 sets err and the run continues.
  - start in RUN is ignored.
  - The next accepted start clears err.
- **Reset mid-DRAIN**: all outputs go to 0 within the same cycle, no done pulse; a following start begins a clean run.
